// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory enable codes and FSM states.
package lsu_pkg;

    localparam logic [1:0] MEM_EN_NONE = 2'b00;
    localparam logic [1:0] MEM_EN_BYTE = 2'b01;
    localparam logic [1:0] MEM_EN_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: word loads pass through, byte loads take [7:0] and extend.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rd_data,
    input  logic              word,
    input  logic              is_signed,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = rd_data;
        if (!word) begin
            result = {{(DATA_W-8){is_signed & rd_data[7]}}, rd_data[7:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator towards a registered data memory port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic              req_word,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_write_enable,
    output logic [1:0]        mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count
);

    lsu_state_t state, state_next;

    logic store_q;
    logic word_q;
    logic sign_q;
    logic accept;
    logic resp_done;
    logic [DATA_W-1:0] load_data;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid & req_ready;
    assign resp_done  = resp_valid & resp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   state_next = store_q ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_q <= 1'b0;
            word_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else if (accept) begin
            store_q <= req_store;
            word_q  <= req_word;
            sign_q  <= req_signed;
        end
    end

    // Memory pins are loaded on the accept edge so they are live for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= MEM_EN_NONE;
            mem_read_enable  <= MEM_EN_NONE;
        end else begin
            mem_write_enable <= MEM_EN_NONE;
            mem_read_enable  <= MEM_EN_NONE;
            if (accept) begin
                mem_address <= req_addr;
                if (req_store) begin
                    mem_write_data   <= req_wdata;
                    mem_write_enable <= req_word ? MEM_EN_WORD : MEM_EN_BYTE;
                end else begin
                    mem_read_enable  <= req_word ? MEM_EN_WORD : MEM_EN_BYTE;
                end
            end
        end
    end

    lsu_load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .rd_data   (mem_read_data),
        .word      (word_q),
        .is_signed (sign_q),
        .result    (load_data)
    );

    // Cleared on accept so stores respond with zero; loads overwrite it in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_rdata <= '0;
        end else if (accept) begin
            resp_rdata <= '0;
        end else if (state == WAIT) begin
            resp_rdata <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (resp_done) begin
            if (store_q) begin
                store_count <= store_count + CNT_W'(1);
            end else begin
                load_count  <= load_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered 1-cycle data memory model.
module tb_load_store_unit;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic              req_word;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_write_enable;
    logic [1:0]        mem_read_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic [CNT_W-1:0]  load_count;
    logic [CNT_W-1:0]  store_count;

    logic [DATA_W-1:0] mem [0:4095];

    int vectors     = 0;
    int miscompares = 0;
    int n_loads     = 0;
    int n_stores    = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_word         (req_word),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .load_count       (load_count),
        .store_count      (store_count)
    );

    always @(posedge clk) begin
        if (mem_write_enable == 2'b10) mem[mem_address] <= mem_write_data;
        else if (mem_write_enable == 2'b01) mem[mem_address][7:0] <= mem_write_data[7:0];
        if (mem_read_enable != 2'b00) mem_read_data <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after completion.
    task automatic run_op(input logic st, input logic wd, input logic sg,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic [31:0] exp_mem);
        req_valid = 1'b1; req_store = st; req_word = wd; req_signed = sg;
        req_addr = addr; req_wdata = wdata;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("issue_we", {30'b0, mem_write_enable}, st ? (wd ? 32'd2 : 32'd1) : 32'd0);
        chk("issue_re", {30'b0, mem_read_enable}, st ? 32'd0 : (wd ? 32'd2 : 32'd1));
        chk("issue_addr", {20'b0, mem_address}, {20'b0, addr});
        if (st) chk("issue_wdata", {24'b0, mem_write_data[7:0]}, {24'b0, wdata[7:0]});
        chk("issue_resp_valid", {31'b0, resp_valid}, 32'd0);
        if (!st) begin
            @(negedge clk);
            chk("wait_en", {28'b0, mem_write_enable, mem_read_enable}, 32'd0);
            chk("wait_resp_valid", {31'b0, resp_valid}, 32'd0);
        end
        @(negedge clk);
        chk("resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("resp_rdata", resp_rdata, exp_rd);
        @(negedge clk);
        if (st) begin
            n_stores++;
            chk("store_count", {30'b0, store_count}, n_stores % 4);
            chk("mem_after_store", mem[addr], exp_mem);
        end else begin
            n_loads++;
            chk("load_count", {30'b0, load_count}, n_loads % 4);
        end
        chk("back_idle", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[40] = 32'h0BADF00D;
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_word = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_en", {28'b0, mem_write_enable, mem_read_enable}, 32'd0);
        chk("rst_counts", {28'b0, load_count, store_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Word store aborted by reset while in ISSUE.
        req_valid = 1'b1; req_store = 1'b1; req_word = 1'b1; req_addr = 12'd40;
        req_wdata = 32'h11111111;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_we_before", {30'b0, mem_write_enable}, 32'd2);
        reset_n = 1'b0;
        #1;
        chk("abort_we_now", {30'b0, mem_write_enable}, 32'd0);
        chk("abort_idle", {31'b0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_mem", mem[40], 32'h0BADF00D);
        chk("abort_counts", {28'b0, load_count, store_count}, 32'd0);
        @(negedge clk);

        run_op(1'b1, 1'b0, 1'b0, 12'd16, 32'h123456AA, 32'h0, 32'h000000AA);
        run_op(1'b1, 1'b1, 1'b0, 12'd32, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
        run_op(1'b0, 1'b1, 1'b0, 12'd32, 32'h0, 32'hDEADBEEF, 32'h0);
        run_op(1'b0, 1'b0, 1'b1, 12'd16, 32'h0, 32'hFFFFFFAA, 32'h0);
        run_op(1'b0, 1'b0, 1'b0, 12'd16, 32'h0, 32'h000000AA, 32'h0);
        run_op(1'b0, 1'b0, 1'b1, 12'd32, 32'h0, 32'hFFFFFFEF, 32'h0);
        run_op(1'b1, 1'b1, 1'b0, 12'd48, 32'h80C0FFEE, 32'h0, 32'h80C0FFEE);
        run_op(1'b1, 1'b0, 1'b0, 12'd48, 32'hFFFFFF55, 32'h0, 32'h80C0FF55);
        run_op(1'b0, 1'b0, 1'b1, 12'd48, 32'h0, 32'h00000055, 32'h0);

        // Backpressure on a word load, with a competing store request held high.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_word = 1'b1; req_addr = 12'd48;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("bp_rdata", resp_rdata, 32'h80C0FF55);
        req_valid = 1'b1; req_store = 1'b1; req_word = 1'b0; req_addr = 12'd20;
        req_wdata = 32'h0000007F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_hold_rdata", resp_rdata, 32'h80C0FF55);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_no_we", {30'b0, mem_write_enable}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_loads++;
        chk("bp_load_count", {30'b0, load_count}, n_loads % 4);
        chk("bp_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_new_we", {30'b0, mem_write_enable}, 32'd1);
        chk("bp_new_addr", {20'b0, mem_address}, 32'd20);
        @(negedge clk);
        chk("bp_new_resp", {31'b0, resp_valid}, 32'd1);
        chk("bp_new_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        n_stores++;
        chk("wrap_store_count", {30'b0, store_count}, n_stores % 4);
        chk("bp_new_mem", mem[20], 32'h0000007F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
